// File: rtl/intensity_colorizer_pkg.sv
// Shared constants for the intensity -> RGB colorizer: channel width, pixel modes
// and the power-on palette/tint contents.
package intensity_colorizer_pkg;

   localparam int CZ_DW = 10;

   typedef enum logic [1:0] {
      MODE_GREY = 2'd0,
      MODE_PAL  = 2'd1,
      MODE_TINT = 2'd2,
      MODE_RSVD = 2'd3
   } mode_e;

   // White: tint at full scale leaves the intensity nearly unchanged.
   localparam logic [3*CZ_DW-1:0] DEFAULT_TINT = {3{{CZ_DW{1'b1}}}};

   // Evenly spaced grey ramp from 0 to full scale across the palette entries.
   function automatic int default_level(input int k, input int bands, input int dw);
      return (((1 << dw) - 1) * k) / (bands - 1);
   endfunction

endpackage

// File: rtl/intensity_colorizer_palette.sv
// Posterize palette: BANDS entries of packed {R,G,B}, one write port and one
// combinational read port; reset reloads the evenly spaced grey ramp.
module colorizer_palette
   import intensity_colorizer_pkg::*;
#(
   parameter int LOG2_BANDS = 3,
   parameter int DW         = CZ_DW
)(
   input  logic                  iCLK,
   input  logic                  iRST,
   input  logic                  we,
   input  logic [LOG2_BANDS-1:0] waddr,
   input  logic [3*DW-1:0]       wdata,
   input  logic [LOG2_BANDS-1:0] raddr,
   output logic [3*DW-1:0]       rdata
);

   localparam int BANDS = 2 ** LOG2_BANDS;

   logic [3*DW-1:0] mem [BANDS];

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         for (int k = 0; k < BANDS; k++) begin
            mem[k] <= {3{DW'(default_level(k, BANDS, DW))}};
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read returns the pre-edge contents, so a same-cycle write is not seen.
   assign rdata = mem[raddr];

endmodule

// File: rtl/intensity_colorizer.sv
// Intensity -> RGB colorizer: grey, palette posterize or tinted output per pixel,
// three-stage pipeline between the intensity filters and the VGA controller.
module intensity_colorizer
   import intensity_colorizer_pkg::*;
#(
   parameter int LOG2_BANDS = 3,
   parameter int DW         = CZ_DW
)(
   input  logic                  iCLK,
   input  logic                  iRST,
   input  logic [DW-1:0]         iIntensity,
   input  logic                  iValid,
   input  logic [1:0]            iMode,
   input  logic                  iPalWe,
   input  logic [LOG2_BANDS-1:0] iPalAddr,
   input  logic [3*DW-1:0]       iPalData,
   input  logic                  iTintWe,
   input  logic [3*DW-1:0]       iTintData,
   output logic [DW-1:0]         oR,
   output logic [DW-1:0]         oG,
   output logic [DW-1:0]         oB,
   output logic                  oValid
);

   // Handshake: iValid qualifies iIntensity/iMode on each clock edge; there is no
   // ready, every valid pixel is accepted and reappears with oValid three edges later.

   logic                  s1_valid;
   logic [DW-1:0]         s1_i;
   mode_e                 s1_mode;
   logic [LOG2_BANDS-1:0] s1_band;

   logic                  s2_valid;
   logic [DW-1:0]         s2_i;
   mode_e                 s2_mode;
   logic [3*DW-1:0]       s2_pal;
   logic [3*DW-1:0]       s2_tint;

   logic [3*DW-1:0]       tint_q;
   logic [3*DW-1:0]       pal_rd;
   logic [2*DW-1:0]       prod_r, prod_g, prod_b;
   logic [3*DW-1:0]       colour;

   assign s1_band = s1_i[DW-1 -: LOG2_BANDS];

   colorizer_palette #(
      .LOG2_BANDS (LOG2_BANDS),
      .DW         (DW)
   ) u_palette (
      .iCLK  (iCLK),
      .iRST  (iRST),
      .we    (iPalWe),
      .waddr (iPalAddr),
      .wdata (iPalData),
      .raddr (s1_band),
      .rdata (pal_rd)
   );

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         tint_q <= {3{{DW{1'b1}}}};
      end else if (iTintWe) begin
         tint_q <= iTintData;
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         s1_valid <= 1'b0;
         s1_i     <= '0;
         s1_mode  <= MODE_GREY;
      end else begin
         s1_valid <= iValid;
         if (iValid) begin
            s1_i    <= iIntensity;
            s1_mode <= mode_e'(iMode);
         end
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         s2_valid <= 1'b0;
         s2_i     <= '0;
         s2_mode  <= MODE_GREY;
         s2_pal   <= '0;
         s2_tint  <= '0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_i    <= s1_i;
            s2_mode <= s1_mode;
            s2_pal  <= pal_rd;
            s2_tint <= tint_q;
         end
      end
   end

   // Keeping the upper DW bits of I*C truncates, so full scale gives 1022, not 1023.
   assign prod_r = {{DW{1'b0}}, s2_i} * {{DW{1'b0}}, s2_tint[3*DW-1 -: DW]};
   assign prod_g = {{DW{1'b0}}, s2_i} * {{DW{1'b0}}, s2_tint[2*DW-1 -: DW]};
   assign prod_b = {{DW{1'b0}}, s2_i} * {{DW{1'b0}}, s2_tint[DW-1:0]};

   always_comb begin
      colour = {3{s2_i}};
      case (s2_mode)
         MODE_PAL:  colour = s2_pal;
         MODE_TINT: colour = {prod_r[2*DW-1:DW], prod_g[2*DW-1:DW], prod_b[2*DW-1:DW]};
         default:   colour = {3{s2_i}};
      endcase
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         oValid <= 1'b0;
         oR     <= '0;
         oG     <= '0;
         oB     <= '0;
      end else begin
         oValid <= s2_valid;
         if (s2_valid) begin
            {oR, oG, oB} <= colour;
         end
      end
   end

endmodule

// File: tb/tb_intensity_colorizer.sv
// Directed bench for intensity_colorizer: reference model plus per-cycle compare
// and hand-computed literal expectations.
module tb_intensity_colorizer;

   logic        iCLK = 1'b0;
   logic        iRST;
   logic [9:0]  iIntensity;
   logic        iValid;
   logic [1:0]  iMode;
   logic        iPalWe;
   logic [2:0]  iPalAddr;
   logic [29:0] iPalData;
   logic        iTintWe;
   logic [29:0] iTintData;
   logic [9:0]  oR, oG, oB;
   logic        oValid;

   int n_checks = 0;
   int n_errors = 0;

   intensity_colorizer #(.LOG2_BANDS(3), .DW(10)) dut (
      .iCLK       (iCLK),
      .iRST       (iRST),
      .iIntensity (iIntensity),
      .iValid     (iValid),
      .iMode      (iMode),
      .iPalWe     (iPalWe),
      .iPalAddr   (iPalAddr),
      .iPalData   (iPalData),
      .iTintWe    (iTintWe),
      .iTintData  (iTintData),
      .oR         (oR),
      .oG         (oG),
      .oB         (oB),
      .oValid     (oValid)
   );

   // ---------------- clock ----------------
   always #5 iCLK = ~iCLK;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish (actual=running required=done)");
      $fatal(1, "timeout");
   end

   // ---------------- reference model ----------------
   typedef struct packed { logic v; logic [9:0] i; logic [1:0] m; } pix_t;
   typedef struct packed { logic v; logic [29:0] rgb; } col_t;

   logic [29:0] m_pal [8];
   logic [29:0] m_tint;
   pix_t        raw_prev;
   col_t        col_prev;
   col_t        exp_now;
   logic [29:0] last_rgb;

   function automatic col_t colour_of(input pix_t p);
      col_t c;
      int   r, g, b;
      c.v = p.v;
      r = (int'(p.i) * int'(m_tint[29:20])) / 1024;
      g = (int'(p.i) * int'(m_tint[19:10])) / 1024;
      b = (int'(p.i) * int'(m_tint[9:0]))   / 1024;
      case (p.m)
         2'd1:    c.rgb = m_pal[p.i / 128];
         2'd2:    c.rgb = {r[9:0], g[9:0], b[9:0]};
         default: c.rgb = {p.i, p.i, p.i};
      endcase
      return c;
   endfunction

   // Pixel sampled at edge n picks up palette/tint at edge n+1 and shows after edge n+2.
   always @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         for (int k = 0; k < 8; k++) begin
            logic [9:0] lvl;
            lvl = 10'((1023 * k) / 7);
            m_pal[k] = {lvl, lvl, lvl};
         end
         m_tint   = {3{10'd1023}};
         raw_prev = '0;
         col_prev = '0;
         exp_now  = '0;
         last_rgb = '0;
      end else begin
         exp_now = col_prev;
         if (exp_now.v) last_rgb = exp_now.rgb;
         col_prev = colour_of(raw_prev);
         raw_prev = '{v: iValid, i: iIntensity, m: iMode};
         if (iPalWe)  m_pal[iPalAddr] = iPalData;
         if (iTintWe) m_tint = iTintData;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge iCLK) begin
      n_checks++;
      if (oValid !== exp_now.v) begin
         n_errors++;
         $display("FAIL model_valid t=%0t: actual=%0b required=%0b", $time, oValid, exp_now.v);
      end
      n_checks++;
      if ({oR, oG, oB} !== last_rgb) begin
         n_errors++;
         $display("FAIL model_rgb t=%0t: actual=%0d,%0d,%0d required=%0d,%0d,%0d", $time,
                  oR, oG, oB, last_rgb[29:20], last_rgb[19:10], last_rgb[9:0]);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check_lit(input string name, input logic v, input logic [29:0] rgb);
      n_checks++;
      if (oValid !== v || {oR, oG, oB} !== rgb) begin
         n_errors++;
         $display("FAIL %s: actual v=%0b rgb=%0d,%0d,%0d required v=%0b rgb=%0d,%0d,%0d", name,
                  oValid, oR, oG, oB, v, rgb[29:20], rgb[19:10], rgb[9:0]);
      end
   endtask

   task automatic drive_pix(input logic [9:0] i, input logic [1:0] m);
      iValid = 1'b1; iIntensity = i; iMode = m;
      @(posedge iCLK); #1;
      iValid = 1'b0;
   endtask

   task automatic pix_check(input logic [9:0] i, input logic [1:0] m, input string name,
                            input logic [29:0] rgb);
      drive_pix(i, m);
      repeat (2) @(posedge iCLK);
      #1 check_lit(name, 1'b1, rgb);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge iCLK);
      #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      iRST = 1'b1; iValid = 1'b0; iIntensity = '0; iMode = '0;
      iPalWe = 1'b0; iPalAddr = '0; iPalData = '0; iTintWe = 1'b0; iTintData = '0;
      idle(3);
      check_lit("reset_state", 1'b0, 30'd0);
      iRST = 1'b0;
      idle(2);

      pix_check(10'd512, 2'd0, "grey_512", {10'd512, 10'd512, 10'd512});
      idle(1);
      check_lit("grey_valid_drop", 1'b0, {10'd512, 10'd512, 10'd512});
      pix_check(10'd300, 2'd3, "mode3_grey", {10'd300, 10'd300, 10'd300});

      pix_check(10'd600,  2'd1, "pal_default_band4", {3{10'd584}});
      pix_check(10'd1023, 2'd1, "pal_default_top",   {3{10'd1023}});
      pix_check(10'd0,    2'd1, "pal_default_zero",  {3{10'd0}});

      // Write lands on the same edge the pixel leaves S2's read: old value wins.
      drive_pix(10'd600, 2'd1);
      iPalWe = 1'b1; iPalAddr = 3'd4; iPalData = {10'd0, 10'd1023, 10'd0};
      @(posedge iCLK); #1;
      iPalWe = 1'b0;
      @(posedge iCLK); #1;
      check_lit("pal_same_cycle_old", 1'b1, {3{10'd584}});

      // Palette and tint written together, both must commit.
      iPalWe = 1'b1; iPalAddr = 3'd4; iPalData = {10'd1023, 10'd0, 10'd0};
      iTintWe = 1'b1; iTintData = {10'd1023, 10'd512, 10'd0};
      @(posedge iCLK); #1;
      iPalWe = 1'b0; iTintWe = 1'b0;
      pix_check(10'd600,  2'd1, "pal_written",  {10'd1023, 10'd0, 10'd0});
      pix_check(10'd512,  2'd2, "tint_512",     {10'd511, 10'd256, 10'd0});
      pix_check(10'd1023, 2'd2, "tint_1023",    {10'd1022, 10'd511, 10'd0});
      idle(2);

      // Bubbles and mixed modes back to back.
      drive_pix(10'd700, 2'd0);
      idle(1);
      drive_pix(10'd900, 2'd1);
      drive_pix(10'd400, 2'd2);
      idle(4);
      for (int n = 0; n < 24; n++) begin
         iValid = ((n % 3) != 1); iIntensity = 10'((n * 149 + 37) % 1024); iMode = 2'(n % 4);
         @(posedge iCLK); #1;
      end
      iValid = 1'b0;
      idle(4);

      // Reset with pixels in flight.
      drive_pix(10'd100, 2'd0);
      drive_pix(10'd600, 2'd1);
      drive_pix(10'd800, 2'd2);
      iValid = 1'b1; iIntensity = 10'd50; iMode = 2'd0;
      #2 iRST = 1'b1;
      #1 check_lit("reset_async", 1'b0, 30'd0);
      iValid = 1'b0;
      idle(2);
      iRST = 1'b0;
      idle(5);
      pix_check(10'd600,  2'd1, "reset_pal_default", {3{10'd584}});
      pix_check(10'd1023, 2'd2, "reset_tint_white",  {3{10'd1022}});
      idle(3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
